// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: issues word fetches over a valid/ready port and keeps an
// in-order queue of {pc, inst} for IF/ID. Redirects flush the queue and drop stale responses.
module ifu_prefetch #(
   parameter int unsigned           ADDR_WIDTH = 64,
   parameter int unsigned           INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] PC_RST     = 64'h80000000,
   parameter int unsigned           DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [INST_WIDTH-1:0] imem_resp_data,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [INST_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] inst_pc
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_WIDTH-1:0] fetch_pc_q;
   logic [PTR_W-1:0]      head_q, tail_q, fill_q;
   logic [CNT_W-1:0]      count_q, pend_q, drop_q;
   logic [DEPTH-1:0]      filled_q, filled_d;
   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem [DEPTH];

   logic                  accept, pop, resp_drop, resp_fill;
   logic [CNT_W:0]        occ;
   logic                  unused_pc_lsbs;

   assign unused_pc_lsbs = ^redirect_pc[1:0];

   // Entries still owed a response (queued or to be dropped) bound the outstanding requests.
   assign occ            = {1'b0, count_q} + {1'b0, drop_q};
   assign imem_req_valid = rst & ~redirect_valid & (occ < (CNT_W+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;

   assign accept    = imem_req_valid & imem_req_ready;
   assign resp_drop = imem_resp_valid & (drop_q != '0);
   assign resp_fill = imem_resp_valid & (drop_q == '0);

   assign inst_valid = (count_q != '0) & filled_q[head_q];
   assign pop        = inst_valid & inst_ready;
   assign inst       = inst_valid ? inst_mem[head_q] : '0;
   assign inst_pc    = inst_valid ? pc_mem[head_q]   : '0;

   always_comb begin
      filled_d = filled_q;
      if (accept)    filled_d[tail_q] = 1'b0;
      if (resp_fill) filled_d[fill_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= PC_RST;
         head_q     <= '0;
         tail_q     <= '0;
         fill_q     <= '0;
         count_q    <= '0;
         pend_q     <= '0;
         drop_q     <= '0;
         filled_q   <= '0;
      end else if (redirect_valid) begin
         // Every unfilled entry becomes a response to throw away, less the one arriving now.
         fetch_pc_q <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         head_q     <= '0;
         tail_q     <= '0;
         fill_q     <= '0;
         count_q    <= '0;
         pend_q     <= '0;
         drop_q     <= drop_q + pend_q - CNT_W'(imem_resp_valid);
         filled_q   <= '0;
      end else begin
         if (accept) begin
            fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
            tail_q     <= tail_q + PTR_W'(1);
         end
         if (pop)       head_q <= head_q + PTR_W'(1);
         if (resp_fill) fill_q <= fill_q + PTR_W'(1);
         if (resp_drop) drop_q <= drop_q - CNT_W'(1);
         count_q  <= count_q + CNT_W'(accept) - CNT_W'(pop);
         pend_q   <= pend_q + CNT_W'(accept) - CNT_W'(resp_fill);
         filled_q <= filled_d;
      end
   end

   // Payload storage carries no reset; filled_q/count_q qualify every read.
   always_ff @(posedge clk) begin
      if (accept)    pc_mem[tail_q]   <= fetch_pc_q;
      if (resp_fill) inst_mem[fill_q] <= imem_resp_data;
   end

   a_resp_expected: assert property (@(posedge clk) disable iff (!rst)
      imem_resp_valid |-> ((drop_q != '0) || (pend_q != '0)));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: a table of per-cycle vectors plus hand-written
// redirect, wrap and reset sequences against an in-order variable-latency memory.
module tb_ifu_prefetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;

   ifu_prefetch dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc)
   );

   always #5 clk = ~clk;

   typedef struct { logic [63:0] addr; int due; } req_t;
   typedef struct { logic [63:0] pc; logic [31:0] ins; } pop_t;
   typedef struct {
      bit          rst_first;
      bit          ir;
      bit          rv;
      logic [63:0] addr;
      bit          iv;
      logic [63:0] pc;
   } vec_t;

   req_t mq[$];
   pop_t popped[$];
   vec_t vt[16];
   int   cyc, lat;
   int   pass_cnt = 0;
   int   chk_cnt  = 0;

   function automatic logic [31:0] ei(input logic [63:0] a);
      return ~a[31:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   task automatic drive_mem();
      req_t r;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
         r = mq.pop_front();
         imem_resp_valid = 1'b1;
         imem_resp_data  = ei(r.addr);
      end
   endtask

   task automatic tick();
      #1;
      if (imem_req_valid && imem_req_ready) mq.push_back('{addr: imem_req_addr, due: cyc + lat});
      if (inst_valid && inst_ready) popped.push_back('{pc: inst_pc, ins: inst});
      @(posedge clk);
      cyc++;
      @(negedge clk);
      drive_mem();
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem_req_ready = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data = '0;
      inst_ready = 1'b0;
      mq.delete();
      popped.delete();
      #1;
      chk({tag, " rst req_valid"}, 64'(imem_req_valid), 64'd0);
      chk({tag, " rst inst_valid"}, 64'(inst_valid), 64'd0);
      chk({tag, " rst inst"}, 64'(inst), 64'd0);
      chk({tag, " rst inst_pc"}, inst_pc, 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      cyc = 0;
      drive_mem();
   endtask

   task automatic check_pops(input string tag, input logic [63:0] base, input int n);
      chk({tag, " pop count ok"}, 64'(popped.size() >= n), 64'd1);
      for (int i = 0; i < n && i < popped.size(); i++) begin
         chk($sformatf("%s pop%0d pc", tag, i), popped[i].pc, base + 64'(4 * i));
         chk($sformatf("%s pop%0d inst", tag, i), 64'(popped[i].ins), 64'(ei(base + 64'(4 * i))));
      end
   endtask

   initial begin
      rst = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem_req_ready = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data = '0;
      inst_ready = 1'b0;
      lat = 1;
      cyc = 0;

      // rst_first, inst_ready, req_valid, req_addr, inst_valid, inst_pc
      vt[0]  = '{1, 1, 1, 64'h80000000, 0, 64'h0};
      vt[1]  = '{0, 1, 1, 64'h80000004, 0, 64'h0};
      vt[2]  = '{0, 1, 1, 64'h80000008, 1, 64'h80000000};
      vt[3]  = '{0, 1, 1, 64'h8000000C, 1, 64'h80000004};
      vt[4]  = '{0, 1, 1, 64'h80000010, 1, 64'h80000008};
      vt[5]  = '{0, 1, 1, 64'h80000014, 1, 64'h8000000C};
      vt[6]  = '{1, 0, 1, 64'h80000000, 0, 64'h0};
      vt[7]  = '{0, 0, 1, 64'h80000004, 0, 64'h0};
      vt[8]  = '{0, 0, 1, 64'h80000008, 1, 64'h80000000};
      vt[9]  = '{0, 0, 1, 64'h8000000C, 1, 64'h80000000};
      vt[10] = '{0, 0, 0, 64'h0,        1, 64'h80000000};
      vt[11] = '{0, 0, 0, 64'h0,        1, 64'h80000000};
      vt[12] = '{0, 1, 0, 64'h0,        1, 64'h80000000};
      vt[13] = '{0, 1, 1, 64'h80000010, 1, 64'h80000004};
      vt[14] = '{0, 1, 1, 64'h80000014, 1, 64'h80000008};
      vt[15] = '{0, 1, 1, 64'h80000018, 1, 64'h8000000C};

      @(negedge clk);

      // Streaming at zero wait, then back-pressure filling all DEPTH entries
      for (int i = 0; i < 16; i++) begin
         if (vt[i].rst_first) do_reset($sformatf("vec%0d", i));
         lat = 1;
         imem_req_ready = 1'b1;
         inst_ready = vt[i].ir;
         #1;
         chk($sformatf("vec%0d req_valid", i), 64'(imem_req_valid), 64'(vt[i].rv));
         if (vt[i].rv) chk($sformatf("vec%0d req_addr", i), imem_req_addr, vt[i].addr);
         chk($sformatf("vec%0d inst_valid", i), 64'(inst_valid), 64'(vt[i].iv));
         if (vt[i].iv) begin
            chk($sformatf("vec%0d inst_pc", i), inst_pc, vt[i].pc);
            chk($sformatf("vec%0d inst", i), 64'(inst), 64'(ei(vt[i].pc)));
         end
         tick();
      end

      // Redirect with three requests in flight; all three responses must be dropped
      do_reset("t3");
      lat = 4;
      inst_ready = 1'b1;
      repeat (3) tick();
      redirect_valid = 1'b1;
      redirect_pc = 64'h80001002;
      #1;
      chk("t3 no req in redirect", 64'(imem_req_valid), 64'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("t3 resume req_valid", 64'(imem_req_valid), 64'd1);
      chk("t3 resume req_addr", imem_req_addr, 64'h80001000);
      repeat (12) tick();
      check_pops("t3", 64'h80001000, 4);

      // Redirect coincident with a response, two outstanding: one drop remains
      do_reset("t4");
      lat = 2;
      inst_ready = 1'b1;
      repeat (2) tick();
      chk("t4 resp in redirect cycle", 64'(imem_resp_valid), 64'd1);
      redirect_valid = 1'b1;
      redirect_pc = 64'h80003000;
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("t4 resume req_addr", imem_req_addr, 64'h80003000);
      repeat (10) tick();
      check_pops("t4", 64'h80003000, 2);

      // Back-to-back redirects, last target wins, then fetch_pc wraps to zero
      do_reset("t5");
      lat = 1;
      inst_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 64'h80005000;
      tick();
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("t5 req_valid", 64'(imem_req_valid), 64'd1);
      chk("t5 top addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      #1;
      chk("t5 wrapped addr", imem_req_addr, 64'h0);
      tick();
      #1;
      chk("t5 addr after wrap", imem_req_addr, 64'h4);
      chk("t5 inst_valid", 64'(inst_valid), 64'd1);
      chk("t5 inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("t5 inst", 64'(inst), 64'(ei(64'hFFFF_FFFF_FFFF_FFFC)));

      // Reset mid-burst with count=3, drop_cnt=1
      do_reset("t6a");
      lat = 5;
      inst_ready = 1'b0;
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 64'h80002000;
      tick();
      redirect_valid = 1'b0;
      repeat (2) tick();
      #1;
      chk("t6 pre-full req_valid", 64'(imem_req_valid), 64'd1);
      chk("t6 pre-full req_addr", imem_req_addr, 64'h80002008);
      tick();
      #1;
      chk("t6 full req_valid", 64'(imem_req_valid), 64'd0);
      do_reset("t6");
      lat = 1;
      inst_ready = 1'b1;
      #1;
      chk("t6 post req_valid", 64'(imem_req_valid), 64'd1);
      chk("t6 post req_addr", imem_req_addr, 64'h80000000);
      chk("t6 post inst_valid", 64'(inst_valid), 64'd0);
      repeat (6) tick();
      check_pops("t6", 64'h80000000, 3);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
